// File: rtl/ifu_fetch_if.sv
// Instruction-fetch bus bundle: the memory req/gnt/rvalid port plus the IF/ID
// output towards decode. The master side is the fetch unit; the slave side is
// the memory/decode environment.
interface ifu_fetch_if;
  logic        inst_req_o_ifu;
  logic [31:0] inst_addr_o_ifu;
  logic        inst_gnt_i_ifu;
  logic        inst_rvalid_i_ifu;
  logic [31:0] inst_rdata_i_ifu;
  logic [31:0] inst_o_ifu_id;
  logic [31:0] inst_addr_o_ifu_id;
  logic        inst_valid_o_ifu_id;

  modport master (
    output inst_req_o_ifu, inst_addr_o_ifu,
    input  inst_gnt_i_ifu, inst_rvalid_i_ifu, inst_rdata_i_ifu,
    output inst_o_ifu_id, inst_addr_o_ifu_id, inst_valid_o_ifu_id
  );

  modport slave (
    input  inst_req_o_ifu, inst_addr_o_ifu,
    output inst_gnt_i_ifu, inst_rvalid_i_ifu, inst_rdata_i_ifu,
    input  inst_o_ifu_id, inst_addr_o_ifu_id, inst_valid_o_ifu_id
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word fetches,
// and feeds decode through an IF/ID register with jump-flush and hold-stall.
// A one-entry skid buffer catches a response that lands while decode is held.
// Optional performance counters are built only when IFU_PERF_CNT_EN is defined;
// otherwise fetch_cnt_o_ifu/flush_cnt_o_ifu read constant zero.
//
// state  | meaning
// S_REQ  | idle/requesting: req asserted unless jump, hold or buffer full
// S_WAIT | request accepted, waiting for rvalid
// S_KILL | outstanding response squashed by a jump, drop it on arrival
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      jump_to_addr_i_ctrl_ifu,
  input  logic             jump_en_i_ctrl_ifu,
  input  logic             hold_flag_i_ctrl_ifu,
  ifu_fetch_if.master      bus,
  output logic [31:0]      fetch_cnt_o_ifu,
  output logic [31:0]      flush_cnt_o_ifu
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] rsp_addr;
  logic [31:0] id_inst;
  logic [31:0] id_addr;
  logic        id_valid;
  logic [31:0] buf_inst;
  logic [31:0] buf_addr;
  logic        buf_valid;
  logic        rsp_take;

  assign rsp_take = (state == S_WAIT) && bus.inst_rvalid_i_ifu;

  assign bus.inst_req_o_ifu      = (state == S_REQ) && !jump_en_i_ctrl_ifu &&
                                   !hold_flag_i_ctrl_ifu && !buf_valid;
  assign bus.inst_addr_o_ifu     = pc;
  assign bus.inst_o_ifu_id       = id_inst;
  assign bus.inst_addr_o_ifu_id  = id_addr;
  assign bus.inst_valid_o_ifu_id = id_valid;

  // Fetch FSM, PC, skid buffer and IF/ID register; a jump overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      rsp_addr  <= 32'h0;
      id_inst   <= NOP_INST;
      id_addr   <= 32'h0;
      id_valid  <= 1'b0;
      buf_inst  <= 32'h0;
      buf_addr  <= 32'h0;
      buf_valid <= 1'b0;
    end else if (jump_en_i_ctrl_ifu) begin
      pc        <= jump_to_addr_i_ctrl_ifu & ~32'h3;
      id_inst   <= NOP_INST;
      id_valid  <= 1'b0;
      buf_valid <= 1'b0;
      case (state)
        S_WAIT, S_KILL: state <= bus.inst_rvalid_i_ifu ? S_REQ : S_KILL;
        default:        state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (bus.inst_req_o_ifu && bus.inst_gnt_i_ifu) begin
            rsp_addr <= pc;
            pc       <= pc + 32'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT:  if (bus.inst_rvalid_i_ifu) state <= S_REQ;
        S_KILL:  if (bus.inst_rvalid_i_ifu) state <= S_REQ;
        default: state <= S_REQ;
      endcase

      if (!hold_flag_i_ctrl_ifu) begin
        if (buf_valid) begin
          id_inst   <= buf_inst;
          id_addr   <= buf_addr;
          id_valid  <= 1'b1;
          buf_valid <= 1'b0;
        end else if (rsp_take) begin
          id_inst  <= bus.inst_rdata_i_ifu;
          id_addr  <= rsp_addr;
          id_valid <= 1'b1;
        end else begin
          id_inst  <= NOP_INST;
          id_valid <= 1'b0;
        end
      end else if (rsp_take) begin
        buf_inst  <= bus.inst_rdata_i_ifu;
        buf_addr  <= rsp_addr;
        buf_valid <= 1'b1;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic fetch_load;
  assign fetch_load = !jump_en_i_ctrl_ifu && !hold_flag_i_ctrl_ifu &&
                      (buf_valid || rsp_take);

  // Count instructions handed to decode and cycles spent redirecting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o_ifu <= 32'h0;
      flush_cnt_o_ifu <= 32'h0;
    end else begin
      if (fetch_load)         fetch_cnt_o_ifu <= fetch_cnt_o_ifu + 32'd1;
      if (jump_en_i_ctrl_ifu) flush_cnt_o_ifu <= flush_cnt_o_ifu + 32'd1;
    end
  end
`else
  assign fetch_cnt_o_ifu = 32'h0;
  assign flush_cnt_o_ifu = 32'h0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed scenarios followed by random jump/hold/gnt/
// rvalid traffic. A behavioural model tracks the PC and the ordered list of
// responses that must reach decode; a separate monitor pops and compares.
module tb_ifu_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] jump_addr;
  logic        jump_en;
  logic        hold;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  ifu_fetch_if bus();

  ifu_fetch dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .jump_to_addr_i_ctrl_ifu (jump_addr),
    .jump_en_i_ctrl_ifu      (jump_en),
    .hold_flag_i_ctrl_ifu    (hold),
    .bus                     (bus),
    .fetch_cnt_o_ifu         (fetch_cnt),
    .flush_cnt_o_ifu         (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        exp_q[$];
  logic [31:0] model_pc;
  logic        outstanding;
  logic        squashed;
  logic [31:0] out_addr;
  int          wait_cnt;
  int          n_jumps;
  int          n_delivered;
  logic        mon_en;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (~a) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is advanced to reflect the coming edge.
  task automatic cycle(input logic j, input logic [31:0] tgt, input logic h,
                       input logic g, input logic rv_want);
    logic rv;
    logic req_exp;
    @(negedge clk);
    rv = outstanding && (rv_want || wait_cnt >= 4);
    jump_en = j;
    jump_addr = tgt;
    hold = h;
    bus.inst_gnt_i_ifu = g;
    bus.inst_rvalid_i_ifu = rv;
    bus.inst_rdata_i_ifu = rv ? mem_data(out_addr) : $urandom;
    #1;
    req_exp = !outstanding && !j && !h && (exp_q.size() == 0);
    check("req", {31'b0, bus.inst_req_o_ifu}, {31'b0, req_exp});
    check("fetch_addr", bus.inst_addr_o_ifu, model_pc);
    if (j) begin
      model_pc = tgt & ~32'h3;
      exp_q.delete();
      n_jumps++;
      if (outstanding && !rv) squashed = 1'b1;
      if (rv) begin
        outstanding = 1'b0;
        squashed = 1'b0;
      end
    end else begin
      if (rv) begin
        outstanding = 1'b0;
        if (!squashed) exp_q.push_back('{inst: mem_data(out_addr), addr: out_addr});
        squashed = 1'b0;
      end
      if (req_exp && g) begin
        outstanding = 1'b1;
        out_addr = model_pc;
        model_pc = model_pc + 32'd4;
      end
    end
    if (rv || !outstanding) wait_cnt = 0;
    else wait_cnt++;
  endtask

  // Monitor: compare the IF/ID register against the expected delivery queue.
  initial begin
    ent_t e;
    ent_t last;
    last = '{inst: NOP, addr: 32'h0};
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (jump_en) begin
        check("flush_valid", {31'b0, bus.inst_valid_o_ifu_id}, 32'h0);
        check("flush_inst", bus.inst_o_ifu_id, NOP);
      end else if (bus.inst_valid_o_ifu_id) begin
        if (!hold) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", {31'b0, bus.inst_valid_o_ifu_id}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("id_inst", bus.inst_o_ifu_id, e.inst);
            check("id_addr", bus.inst_addr_o_ifu_id, e.addr);
            last = e;
            n_delivered++;
          end
        end else begin
          check("held_inst", bus.inst_o_ifu_id, last.inst);
          check("held_addr", bus.inst_addr_o_ifu_id, last.addr);
        end
      end else begin
        check("bubble_inst", bus.inst_o_ifu_id, NOP);
        if (!hold) check("missing_delivery", exp_q.size(), 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    jump_en = 1'b0;
    jump_addr = 32'h0;
    hold = 1'b0;
    bus.inst_gnt_i_ifu = 1'b0;
    bus.inst_rvalid_i_ifu = 1'b0;
    bus.inst_rdata_i_ifu = 32'h0;
    model_pc = 32'h0;
    outstanding = 1'b0;
    squashed = 1'b0;
    out_addr = 32'h0;
    wait_cnt = 0;
    n_jumps = 0;
    n_delivered = 0;
    mon_en = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, bus.inst_req_o_ifu}, 32'h1);
    check("rst_addr", bus.inst_addr_o_ifu, 32'h0);
    check("rst_id_inst", bus.inst_o_ifu_id, NOP);
    check("rst_id_addr", bus.inst_addr_o_ifu_id, 32'h0);
    check("rst_id_valid", {31'b0, bus.inst_valid_o_ifu_id}, 32'h0);
    check("rst_fetch_cnt", fetch_cnt, 32'h0);
    check("rst_flush_cnt", flush_cnt, 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Back-to-back fetches with a zero-wait memory.
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    // Grant withheld: request must stay up with the PC frozen.
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    // Jump while waiting: response squashed, next fetch at aligned target.
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0102, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("jump_refetch_addr", out_addr, 32'h0000_0100);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    // Response lands under hold: buffered, requests blocked until release.
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    // Jump together with hold while a response sits in the buffer.
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_0203, 1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(15) == 0), $urandom, ($urandom_range(3) == 0),
            ($urandom_range(3) != 0), ($urandom_range(1) == 1));
    end
    repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

`ifdef IFU_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, n_delivered);
    check("flush_cnt", flush_cnt, n_jumps);
`else
    check("fetch_cnt", fetch_cnt, 32'h0);
    check("flush_cnt", flush_cnt, 32'h0);
`endif
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
